// File: rtl/pipeline_hilo_read_pkg.sv
// rtl/pipeline_hilo_read_pkg.sv - shared opcodes, HI/LO write decode and read FSM states
package pipeline_hilo_read_pkg;

  localparam logic [5:0] OP_MULT = 6'b000100;
  localparam logic [5:0] OP_MTHI = 6'b000101;
  localparam logic [5:0] OP_MTLO = 6'b000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returns {hi_w, lo_w}: which special registers a late-ALU opcode writes.
  function automatic logic [1:0] hilo_decode(input logic [5:0] op);
    case (op)
      OP_MULT: return 2'b11;
      OP_MTHI: return 2'b10;
      OP_MTLO: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hilo_pend_tracker.sv
// rtl/hilo_pend_tracker.sv - counts HI/LO writes in flight through the late ALU
module hilo_pend_tracker
  import pipeline_hilo_read_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_issue,
  input  logic [5:0] wr_op,
  output logic       hi_busy,
  output logic       lo_busy
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [1:0]    issue_w;
  logic [1:0]    retire_w;
  logic [CW-1:0] hi_pend;
  logic [CW-1:0] lo_pend;

  assign issue_w = wr_issue ? hilo_decode(wr_op) : 2'b00;

  // An issue and a retirement on the same edge leave the count unchanged.
  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CW'(1);
      2'b01:   return cnt - CW'(1);
      default: return cnt;
    endcase
  endfunction

  generate
    if (LATENCY == 1) begin : g_no_pipe
      // The write is visible one cycle after issue, so it retires as it issues.
      assign retire_w = issue_w;
    end else begin : g_pipe
      logic [1:0] tag_q [LATENCY-1];

      // Tag shift register: the last stage marks the final busy cycle of a write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY - 1; i++) tag_q[i] <= 2'b00;
        end else begin
          tag_q[0] <= issue_w;
          for (int i = 1; i < LATENCY - 1; i++) tag_q[i] <= tag_q[i-1];
        end
      end

      assign retire_w = tag_q[LATENCY-2];
    end
  endgenerate

  // Per-register in-flight write counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_pend <= '0;
      lo_pend <= '0;
    end else begin
      hi_pend <= next_cnt(hi_pend, issue_w[1], retire_w[1]);
      lo_pend <= next_cnt(lo_pend, issue_w[0], retire_w[0]);
    end
  end

  // A write issued this cycle counts as older than a read accepted this cycle.
  assign hi_busy = (hi_pend != '0) || issue_w[1];
  assign lo_busy = (lo_pend != '0) || issue_w[0];

endmodule

// File: rtl/pipeline_hilo_read.sv
// rtl/pipeline_hilo_read.sv - mfhi/mflo read port with hazard wait and response handshake
module pipeline_hilo_read
  import pipeline_hilo_read_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_issue,
  input  logic [5:0]  wr_op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic        rd_valid,
  input  logic        rd_sel,
  output logic        rd_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  input  logic        flush
);

  state_t state;
  logic   sel_q;
  logic   hi_busy;
  logic   lo_busy;

  hilo_pend_tracker #(.LATENCY(LATENCY)) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_issue (wr_issue),
    .wr_op    (wr_op),
    .hi_busy  (hi_busy),
    .lo_busy  (lo_busy)
  );

  // Read FSM; rd_ready is high exactly in IDLE, res_valid exactly in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      rd_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= 32'h0;
    end else if (flush) begin
      state     <= IDLE;
      rd_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_valid) begin
            sel_q    <= rd_sel;
            rd_ready <= 1'b0;
            if (!(rd_sel ? hi_busy : lo_busy)) begin
              res_data  <= rd_sel ? hi : lo;
              res_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!(sel_q ? hi_busy : lo_busy)) begin
            res_data  <= sel_q ? hi : lo;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            rd_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rd_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipeline_hilo_read.md
# pipeline_hilo_read

- Read side of the HI/LO special registers: serves mfhi/mflo requests from the pipeline.
- Tracks HI/LO writes in flight in the late-ALU stage (mult, mthi, mtlo). A read is held until every earlier write to its register is visible. The block then returns the settled value over a valid/ready response handshake.
- Sits between the decode/issue stage and writeback, next to the late ALU.

## Interface
- LATENCY, 1: cycles from a HI/LO write being issued to the late ALU until the new value appears on the late ALU's hi/lo outputs. Legal range 1..4.
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_issue  input  1  a late-ALU operation is issued this cycle.
- wr_op  input  6  opcode of that operation:
  - 6'b000100 mult: writes hi and lo.
  - 6'b000101 mthi: writes hi.
  - 6'b000110 mtlo: writes lo.
  - Any other value writes neither register.
- hi, lo  input  32 each  current HI/LO register values from the late ALU.
- rd_valid  input  1  mfhi/mflo request.
- rd_sel  input  1  selects the register to read: 1 = hi (mfhi), 0 = lo (mflo).
- rd_ready  output  1  request accepted this cycle when rd_valid && rd_ready.
- res_valid  output  1  response data valid.
- res_data  output  32  response value.
- res_ready  input  1  consumer accepts the response.
- flush  input  1  discard any outstanding request.

## Operation
- Pending counters, one per register: hi_pend and lo_pend, each $clog2(LATENCY+1) bits.
  - Increment at the end of the issue cycle N when wr_issue targets that register.
  - Decrement at the end of cycle N+LATENCY-1.
  - Increment and decrement in the same edge cancel.
  - At most one issue per cycle, so a counter never exceeds LATENCY; no overflow handling.
- Issue tags: a 2-bit {hi_w, lo_w} tag pipeline, LATENCY-1 stages deep, generates the decrements. For LATENCY=1 the decrement is the issue itself.
- Pending definition: a register is pending when its counter is nonzero, or when wr_issue targets it in the current cycle.
  - A write issued in the same cycle as a read acceptance is treated as older than the read.
- FSM states:
  - IDLE:
    - rd_ready=1, res_valid=0.
    - On acceptance, latch rd_sel.
    - If the selected register is not pending, capture hi/lo into res_data and go to RESP.
    - Otherwise go to WAIT.
  - WAIT:
    - rd_ready=0.
    - In the first cycle the latched register is not pending, capture its value into res_data and go to RESP.
    - Writes issued while in WAIT also count, so the read waits for them as well.
  - RESP:
    - res_valid=1, res_data held stable.
    - On res_ready, go to IDLE. No back-to-back acceptance in the same cycle.
- flush:
  - Forces the FSM to IDLE next cycle from any state; the pending request or response is dropped.
  - Counters and the tag pipeline are unaffected, because issued writes still complete.
  - flush takes priority over acceptance and over res_ready.
- Reset (asynchronous, any time, including mid-WAIT or mid-RESP):
  - FSM to IDLE; counters, tags and latched rd_sel to 0; res_data to 0.
- Reset values of outputs: rd_ready=1 (IDLE), res_valid=0, res_data=0.

## Timing
- Read not pending, accepted in cycle N: res_valid=1 in cycle N+1, and res_data equals the selected hi/lo value sampled in cycle N.
- Read pending: res_valid rises in the cycle after the first non-pending WAIT cycle.
  - For a write issued in cycle N, that first non-pending cycle is N+LATENCY, so the value returned is the value written.
- res_valid stays high and res_data stays constant until res_ready is sampled high.
- Throughput: at most one request per 2 cycles.

## Structure
- Shared pipeline package holds:
  - opcode constants OP_MULT=6'b000100, OP_MTHI=6'b000101, OP_MTLO=6'b000110.
  - an opcode-to-{hi_w, lo_w} decode function.
  - the FSM state enum: IDLE, WAIT, RESP.
- One natural sub-module, hilo_pend_tracker: opcode decode, tag pipeline and both counters; outputs hi_busy and lo_busy.
- The FSM and response register stay in pipeline_hilo_read.

## Test plan
- Idle read: LATENCY=1, hi=32'hDEADBEEF, no writes; rd_valid, rd_sel=1 in cycle 0 -> res_valid in cycle 1, res_data=32'hDEADBEEF.
- Same-cycle hazard: LATENCY=1. In cycle 0, wr_issue with wr_op=mtlo and rd_valid with rd_sel=0. The lo input changes 0->32'h00000005 from cycle 1 -> FSM enters WAIT; res_valid in cycle 2, res_data=5.
- Mult pending, LATENCY=3:
  - Cycle 0: mult issued, which pends both hi and lo.
  - Cycle 1: mfhi accepted.
  - The hi input becomes 32'h1 from cycle 3.
  - Required: res_valid first high in cycle 4, res_data=32'h1.
  - Also: an mflo issued in its place behaves identically.
- Non-targeting write: mthi issued, mflo accepted the same cycle -> no wait; response next cycle with the current lo value.
- Backpressure: res_ready held low 5 cycles -> res_valid and res_data stable, rd_ready=0 throughout. Response leaves in the cycle res_ready rises; rd_ready=1 the following cycle.
- Flush and reset:
  - flush during WAIT -> IDLE next cycle, no response, counters still drain to 0.
  - rst_n low mid-RESP -> res_valid=0 and res_data=0 immediately (asynchronous).
